// File: rtl/enc_dec_pkg.sv
`default_nettype none
// ============================================================================
// Module   : enc_dec_pkg
// Purpose  : Shared types and constants for the encode/decode select path:
//            FSM state type, code/line widths and the counter width helper.
// Revision : 1.0 - initial release
// ============================================================================
package enc_dec_pkg;

    localparam int CODE_W = 2;
    localparam int LINE_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_GAP    = 2'd2
    } state_t;

    // Counter only ever holds (n-1) for n = max(dwell, gap); at least 1 bit.
    function automatic int cnt_width(input int dwell, input int gap);
        int m;
        m = (dwell > gap) ? dwell : gap;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage
`default_nettype wire

// File: rtl/decoder2x4_strobe_if.sv
`default_nettype none
// ============================================================================
// Module   : decoder2x4_strobe_if
// Purpose  : Code handshake plus strobe outputs of the sequential decoder.
//            master = code source / observer, slave = decoder.
// Revision : 1.0 - initial release
// ============================================================================
interface decoder2x4_strobe_if;
    import enc_dec_pkg::*;

    logic [CODE_W-1:0] din;
    logic              din_valid;
    logic              din_ready;
    logic [LINE_W-1:0] qout;
    logic              busy;
    logic              done;

    modport master (
        output din, din_valid,
        input  din_ready, qout, busy, done
    );

    modport slave (
        input  din, din_valid,
        output din_ready, qout, busy, done
    );

endinterface
`default_nettype wire

// File: rtl/decoder2x4.sv
`default_nettype none
// ============================================================================
// Module   : decoder2x4
// Purpose  : Combinational 2-to-4 one-hot decoder written as explicit
//            AND/NOT gate equations, mirroring the lab encoder.
// Revision : 1.0 - initial release
// ============================================================================
module decoder2x4
    import enc_dec_pkg::*;
(
    input  wire logic [CODE_W-1:0] code_i,
    output logic      [LINE_W-1:0] line_o
);

    logic a0_n;
    logic a1_n;

    assign a0_n = ~code_i[0];
    assign a1_n = ~code_i[1];

    assign line_o[0] = a1_n      & a0_n;
    assign line_o[1] = a1_n      & code_i[0];
    assign line_o[2] = code_i[1] & a0_n;
    assign line_o[3] = code_i[1] & code_i[0];

endmodule
`default_nettype wire

// File: rtl/decoder2x4_strobe.sv
`default_nettype none
// ============================================================================
// Module   : decoder2x4_strobe
// Purpose  : Sequential 2-to-4 decoder. Accepts a code into a one-entry
//            pending slot, strobes the matching select line for DWELL
//            cycles, then holds GAP all-zero cycles (break-before-make).
// Revision : 1.0 - initial release
// ============================================================================
module decoder2x4_strobe
    import enc_dec_pkg::*;
#(
    parameter int DWELL = 4,
    parameter int GAP   = 1
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    decoder2x4_strobe_if.slave bus
);

    localparam int                CNT_W    = cnt_width(DWELL, GAP);
    localparam logic [CNT_W-1:0]  DWELL_LD = CNT_W'(DWELL - 1);
    // GAP load is unused when GAP == 0; clamp so the constant stays legal.
    localparam logic [CNT_W-1:0]  GAP_LD   = CNT_W'((GAP > 0) ? (GAP - 1) : 0);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam bit                HAS_GAP  = (GAP > 0);

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [LINE_W-1:0]   qout_q, qout_d;
    logic                done_q, done_d;
    logic [CODE_W-1:0]   pend_code_q;
    logic                pend_vld_q;
    logic                consume;
    logic                accept;
    logic [LINE_W-1:0]   dec_line;

    // Slot is only refilled when empty, so accept and consume never coincide.
    assign accept = bus.din_valid && !pend_vld_q;

    decoder2x4 u_dec (
        .code_i (pend_code_q),
        .line_o (dec_line)
    );

    // Pending slot: captured on handshake, emptied when the FSM loads it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_vld_q  <= 1'b0;
            pend_code_q <= '0;
        end else if (consume) begin
            pend_vld_q  <= 1'b0;
        end else if (accept) begin
            pend_vld_q  <= 1'b1;
            pend_code_q <= bus.din;
        end
    end

    // State register: FSM state, dwell/gap counter and the registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            qout_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            qout_q  <= qout_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic: load a pending code, count down dwell and gap.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        qout_d  = qout_q;
        done_d  = 1'b0;
        consume = 1'b0;
        case (state_q)
            ST_IDLE: begin
                qout_d = '0;
                if (pend_vld_q) begin
                    state_d = ST_ACTIVE;
                    qout_d  = dec_line;
                    cnt_d   = DWELL_LD;
                    consume = 1'b1;
                end
            end
            ST_ACTIVE: begin
                if (cnt_q == '0) begin
                    done_d = 1'b1;
                    if (HAS_GAP) begin
                        state_d = ST_GAP;
                        qout_d  = '0;
                        cnt_d   = GAP_LD;
                    end else if (pend_vld_q) begin
                        // No gap configured: switch line to line directly.
                        qout_d  = dec_line;
                        cnt_d   = DWELL_LD;
                        consume = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                        qout_d  = '0;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_GAP: begin
                qout_d = '0;
                if (cnt_q == '0) begin
                    if (pend_vld_q) begin
                        state_d = ST_ACTIVE;
                        qout_d  = dec_line;
                        cnt_d   = DWELL_LD;
                        consume = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                qout_d  = '0;
            end
        endcase
    end

    // Output logic: handshake ready, busy status and registered strobes.
    always_comb begin
        bus.din_ready = !pend_vld_q;
        bus.busy      = (state_q != ST_IDLE) || pend_vld_q;
        bus.qout      = qout_q;
        bus.done      = done_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_decoder2x4_strobe.sv
`default_nettype none
// ============================================================================
// Module   : tb_decoder2x4_strobe
// Purpose  : Self-checking bench for decoder2x4_strobe. Three instances
//            (DWELL/GAP = 4/1, 4/0, 1/0) are checked every cycle against a
//            timestamp model: each accepted code starts at
//            max(accept+1, previous start + DWELL + GAP).
// Revision : 1.0 - initial release
// ============================================================================
module tb_decoder2x4_strobe;

    localparam int DW0 = 4, GP0 = 1;
    localparam int DW1 = 4, GP1 = 0;
    localparam int DW2 = 1, GP2 = 0;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    logic [1:0] din_a  [3];
    logic       vld_a  [3];
    logic [3:0] q_a    [3];
    logic       rdy_a  [3];
    logic       busy_a [3];
    logic       done_a [3];

    int cyc    = 0;
    int n_chk  = 0;
    int n_pass = 0;

    // Model: per instance, list of accepted codes with accept and start edge.
    int         m_acc  [3][32];
    int         m_st   [3][32];
    logic [1:0] m_code [3][32];
    int         m_n    [3];
    int         m_last [3];

    logic [3:0] cap [32];

    decoder2x4_strobe_if if0 ();
    decoder2x4_strobe_if if1 ();
    decoder2x4_strobe_if if2 ();

    decoder2x4_strobe #(.DWELL(DW0), .GAP(GP0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
    decoder2x4_strobe #(.DWELL(DW1), .GAP(GP1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
    decoder2x4_strobe #(.DWELL(DW2), .GAP(GP2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));

    assign if0.din = din_a[0];  assign if0.din_valid = vld_a[0];
    assign if1.din = din_a[1];  assign if1.din_valid = vld_a[1];
    assign if2.din = din_a[2];  assign if2.din_valid = vld_a[2];

    assign q_a[0] = if0.qout;  assign rdy_a[0] = if0.din_ready;
    assign q_a[1] = if1.qout;  assign rdy_a[1] = if1.din_ready;
    assign q_a[2] = if2.qout;  assign rdy_a[2] = if2.din_ready;
    assign busy_a[0] = if0.busy;  assign done_a[0] = if0.done;
    assign busy_a[1] = if1.busy;  assign done_a[1] = if1.done;
    assign busy_a[2] = if2.busy;  assign done_a[2] = if2.done;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int dw_of(input int d);
        case (d)
            0:       return DW0;
            1:       return DW1;
            default: return DW2;
        endcase
    endfunction

    function automatic int gp_of(input int d);
        case (d)
            0:       return GP0;
            1:       return GP1;
            default: return GP2;
        endcase
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_chk = n_chk + 1;
        if (act == exp) n_pass = n_pass + 1;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Compare process: state after edge 'cyc' against the model, then log
    // the handshake that the currently driven inputs will make on edge cyc+1.
    always @(negedge clk) begin
        logic [3:0] e_q;
        logic       e_done, e_busy, e_pend;
        int         dw, gp, st;
        if (cyc > 0) begin
            for (int d = 0; d < 3; d++) begin
                if (!rst_n) begin
                    m_n[d]    = 0;
                    m_last[d] = -1000;
                    chk($sformatf("dut%0d rst qout c%0d", d, cyc), int'(q_a[d]), 0);
                    chk($sformatf("dut%0d rst ready c%0d", d, cyc), int'(rdy_a[d]), 1);
                    chk($sformatf("dut%0d rst busy c%0d", d, cyc), int'(busy_a[d]), 0);
                    chk($sformatf("dut%0d rst done c%0d", d, cyc), int'(done_a[d]), 0);
                end else begin
                    dw = dw_of(d);
                    gp = gp_of(d);
                    e_q = 4'b0000; e_done = 1'b0; e_busy = 1'b0; e_pend = 1'b0;
                    for (int i = 0; i < m_n[d]; i++) begin
                        st = m_st[d][i];
                        if (cyc >= st && cyc < st + dw) e_q = 4'b0001 << m_code[d][i];
                        if (cyc == st + dw) e_done = 1'b1;
                        if (cyc >= st && cyc < st + dw + gp) e_busy = 1'b1;
                        if (cyc >= m_acc[d][i] && cyc < st) begin
                            e_pend = 1'b1;
                            e_busy = 1'b1;
                        end
                    end
                    chk($sformatf("dut%0d qout c%0d", d, cyc), int'(q_a[d]), int'(e_q));
                    chk($sformatf("dut%0d done c%0d", d, cyc), int'(done_a[d]), int'(e_done));
                    chk($sformatf("dut%0d busy c%0d", d, cyc), int'(busy_a[d]), int'(e_busy));
                    chk($sformatf("dut%0d ready c%0d", d, cyc), int'(rdy_a[d]), int'(!e_pend));
                    chk($sformatf("dut%0d onehot0 c%0d", d, cyc), int'($onehot0(q_a[d])), 1);
                    if (vld_a[d] && !e_pend && m_n[d] < 32) begin
                        m_acc[d][m_n[d]]  = cyc + 1;
                        m_st[d][m_n[d]]   = (cyc + 2 > m_last[d] + dw + gp) ? cyc + 2
                                                                            : m_last[d] + dw + gp;
                        m_code[d][m_n[d]] = din_a[d];
                        m_last[d]         = m_st[d][m_n[d]];
                        m_n[d]            = m_n[d] + 1;
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offers codes back to back; cap[t] holds qout after the t-th edge
    // counted from the first offer edge.
    task automatic stream(input int d, input logic [7:0] codes, input int n,
                          input int cycles, output int dcnt, output int stalls);
        logic acc;
        int   idx;
        idx = 0; dcnt = 0; stalls = 0;
        din_a[d] = codes[1:0];
        vld_a[d] = 1'b1;
        for (int t = 0; t < cycles; t++) begin
            acc = vld_a[d] && rdy_a[d];
            if (vld_a[d] && !rdy_a[d]) stalls = stalls + 1;
            tick();
            if (acc) begin
                idx = idx + 1;
                if (idx < n) din_a[d] = codes[2*idx +: 2];
                else         vld_a[d] = 1'b0;
            end
            cap[t] = q_a[d];
            if (done_a[d]) dcnt = dcnt + 1;
        end
        vld_a[d] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, passed %0d of %0d", n_pass, n_chk);
        $fatal(1);
    end

    initial begin
        logic [3:0] exp2 [15];
        logic [3:0] exp3 [10];
        logic [3:0] exp5 [9];
        int dcnt, stalls;
        for (int d = 0; d < 3; d++) begin
            din_a[d] = 2'd0;
            vld_a[d] = 1'b0;
        end
        exp2 = '{4'h0, 4'h1, 4'h1, 4'h1, 4'h1, 4'h0, 4'h8, 4'h8, 4'h8, 4'h8,
                 4'h0, 4'h2, 4'h2, 4'h2, 4'h2};
        exp3 = '{4'h0, 4'h2, 4'h2, 4'h2, 4'h2, 4'h4, 4'h4, 4'h4, 4'h4, 4'h0};
        exp5 = '{4'h0, 4'h1, 4'h0, 4'h2, 4'h0, 4'h4, 4'h0, 4'h8, 4'h0};

        // Reset state
        repeat (3) tick();
        chk("reset qout", int'(q_a[0]), 0);
        chk("reset ready", int'(rdy_a[0]), 1);
        chk("reset busy", int'(busy_a[0]), 0);
        chk("reset done", int'(done_a[0]), 0);
        rst_n = 1'b1;
        repeat (2) tick();

        // Single code 2: 0100 for four cycles, then zero with done
        din_a[0] = 2'd2;
        vld_a[0] = 1'b1;
        tick();
        vld_a[0] = 1'b0;
        din_a[0] = 2'd3;
        chk("single busy after accept", int'(busy_a[0]), 1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("single qout dwell %0d", i), int'(q_a[0]), 4);
        end
        tick();
        chk("single qout end", int'(q_a[0]), 0);
        chk("single done", int'(done_a[0]), 1);
        tick();
        chk("single idle busy", int'(busy_a[0]), 0);
        chk("single done once", int'(done_a[0]), 0);
        repeat (2) tick();

        // Back-to-back 0,3,1 with backpressure on the third code
        stream(0, 8'b00_01_11_00, 3, 18, dcnt, stalls);
        for (int t = 0; t < 15; t++)
            chk($sformatf("b2b qout t%0d", t), int'(cap[t]), int'(exp2[t]));
        chk("b2b done count", dcnt, 3);
        chk("b2b stall cycles", stalls, 5);
        repeat (2) tick();

        // GAP=0: 0010 straight into 0100
        stream(1, 8'b00_00_10_01, 2, 12, dcnt, stalls);
        for (int t = 0; t < 10; t++)
            chk($sformatf("gap0 qout t%0d", t), int'(cap[t]), int'(exp3[t]));
        chk("gap0 done count", dcnt, 2);
        repeat (2) tick();

        // DWELL=1, GAP=0: all four codes
        stream(2, 8'b11_10_01_00, 4, 12, dcnt, stalls);
        for (int t = 0; t < 9; t++)
            chk($sformatf("dw1 qout t%0d", t), int'(cap[t]), int'(exp5[t]));
        chk("dw1 done count", dcnt, 4);
        repeat (2) tick();

        // Asynchronous reset mid-dwell with a code pending
        stream(0, 8'b00_00_10_01, 2, 3, dcnt, stalls);
        chk("prereset qout", int'(q_a[0]), 2);
        chk("prereset busy", int'(busy_a[0]), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async rst qout", int'(q_a[0]), 0);
        chk("async rst ready", int'(rdy_a[0]), 1);
        chk("async rst busy", int'(busy_a[0]), 0);
        repeat (2) tick();
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk($sformatf("post rst qout %0d", i), int'(q_a[0]), 0);
            chk($sformatf("post rst busy %0d", i), int'(busy_a[0]), 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
